// File: rtl/seq_muldiv_if.sv
// rtl/seq_muldiv_if.sv - request/result bundle for the sequential multiply/divide unit
//
// Signals (master = requester, slave = seq_muldiv):
//   start, op, sgn, a, b   request side, driven by the master
//   busy, done             status, driven by the slave
//   hi, lo, div_zero       registered result, driven by the slave
interface seq_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, sgn, a, b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, sgn, a, b,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative shift-add multiplier / restoring divider
//
// Ports:
//   clock   single rising-edge clock
//   clear   synchronous active-high reset; aborts any request in flight
//   bus     seq_muldiv_if.slave: start/op/sgn/a/b in, busy/done/hi/lo/div_zero out
//
// op = 0 multiply: hi:lo = a * b (full 2*WIDTH product)
// op = 1 divide:   lo = quotient (truncated toward zero), hi = remainder
// sgn = 1 treats a and b as two's complement. Result appears with a one-cycle
// done pulse WIDTH+1 edges after the accepting edge.
module seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic        clock,
    input  logic        clear,
    seq_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               op_q;
    logic               neg_a_q;
    logic               neg_b_q;
    logic               bzero_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   mag_b_q;
    // Multiply: upper half accumulates partial product, lower half holds the
    // multiplier being shifted out. Divide: upper half is the partial
    // remainder, lower half shifts dividend bits out and quotient bits in.
    logic [2*WIDTH-1:0] acc_q;

    logic               busy_q;
    logic               done_q;
    logic               div_zero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Operand magnitudes at the accepting edge
    logic               neg_a_in;
    logic               neg_b_in;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;

    // One iteration of each algorithm
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]     trial;
    logic               trial_ok;
    logic [WIDTH-1:0]   rem_step;
    logic [2*WIDTH-1:0] div_acc_d;

    // Sign-corrected results
    logic               flip_q;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic               div_zero_d;

    always_comb begin
        neg_a_in = bus.sgn & bus.a[WIDTH-1];
        neg_b_in = bus.sgn & bus.b[WIDTH-1];
        mag_a_in = neg_a_in ? -bus.a : bus.a;
        mag_b_in = neg_b_in ? -bus.b : bus.b;
    end

    always_comb begin
        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, mag_b_q} : {(WIDTH+1){1'b0}});
        mul_acc_d = {add_sum, acc_q[WIDTH-1:1]};

        // Shift the next dividend bit into the remainder and try a subtract;
        // keep the shifted remainder (restore) when the subtract would borrow.
        trial     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mag_b_q};
        trial_ok  = ~trial[WIDTH];
        rem_step  = trial_ok ? trial[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1];
        div_acc_d = {rem_step, acc_q[WIDTH-2:0], trial_ok};
    end

    always_comb begin
        // neg flags are already gated by sgn at capture, so unsigned never flips
        flip_q   = neg_a_q ^ neg_b_q;
        prod_fix = flip_q ? -acc_q : acc_q;
        quo_fix  = flip_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        div_zero_d = 1'b0;
        if (!op_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end else if (bzero_q) begin
            // Divide by zero returns the raw dividend, not the magnitude path
            hi_d       = a_q;
            lo_d       = {WIDTH{1'b1}};
            div_zero_d = 1'b1;
        end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            bzero_q    <= 1'b0;
            a_q        <= '0;
            mag_b_q    <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        neg_a_q <= neg_a_in;
                        neg_b_q <= neg_b_in;
                        bzero_q <= (bus.b == '0);
                        a_q     <= bus.a;
                        mag_b_q <= mag_b_in;
                        acc_q   <= {{WIDTH{1'b0}}, mag_a_in};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= op_q ? div_acc_d : mul_acc_d;
                    cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    hi_q       <= hi_d;
                    lo_q       <= lo_d;
                    div_zero_q <= div_zero_d;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_seq_muldiv.sv
// tb/tb_seq_muldiv.sv - scoreboard bench for seq_muldiv (WIDTH = 32)
module tb_seq_muldiv;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic clock;
    logic clear;
    int   total;
    int   bad;
    exp_t sb_q[$];

    seq_muldiv_if #(.WIDTH(W)) bus ();

    seq_muldiv #(.WIDTH(W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clock) begin
        if (!clear && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("hi", {32'd0, bus.hi}, {32'd0, e.hi});
                chk("lo", {32'd0, bus.lo}, {32'd0, e.lo});
                chk("div_zero", {63'd0, bus.div_zero}, {63'd0, e.dz});
            end
        end
    end

    // Issue one request from IDLE and watch it for 40 edges.
    // inject_k: edge after which a bogus start is pulsed (0 = none).
    // abort_k:  edge after which clear is asserted (0 = none).
    task automatic run(input logic op, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ehi,
                       input logic [W-1:0] elo, input logic edz,
                       input int inject_k, input int abort_k);
        int ndone;
        int lat;
        bit aborted;
        ndone   = 0;
        lat     = 0;
        aborted = 0;
        bus.op    = op;
        bus.sgn   = sgn;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        // Operands change after acceptance; result must not move
        bus.a   = ~a;
        bus.b   = b + 32'd3;
        bus.sgn = ~sgn;
        bus.op  = ~op;
        if (abort_k == 0) sb_q.push_back('{hi: ehi, lo: elo, dz: edz});
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (clear) begin
                clear = 1'b0;
                aborted = 1;
                chk("abort_busy", {63'd0, bus.busy}, 64'd0);
                chk("abort_done", {63'd0, bus.done}, 64'd0);
                chk("abort_hi", {32'd0, bus.hi}, 64'd0);
                chk("abort_lo", {32'd0, bus.lo}, 64'd0);
                break;
            end
            if (bus.done) begin
                ndone++;
                if (lat == 0) lat = k;
            end
            if (k == inject_k) begin
                bus.start = 1'b1;
                bus.a     = 32'd100;
                bus.b     = 32'd7;
            end else begin
                bus.start = 1'b0;
            end
            if (k == abort_k) clear = 1'b1;
        end
        if (abort_k != 0) begin
            chk("abort_seen", {63'd0, aborted}, 64'd1);
            chk("abort_no_done", 64'(ndone), 64'd0);
        end else begin
            chk("latency", 64'(lat), 64'd33);
            chk("done_count", 64'(ndone), 64'd1);
        end
    endtask

    initial begin
        int t1;
        int t2;
        total     = 0;
        bad       = 0;
        clear     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.sgn   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clock);
        #1;
        clear = 1'b0;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("rst_lo", {32'd0, bus.lo}, 64'd0);
        chk("rst_dz", {63'd0, bus.div_zero}, 64'd0);

        // clear wins over start on the same edge
        clear     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        @(posedge clock);
        #1;
        clear     = 1'b0;
        bus.start = 1'b0;
        @(posedge clock);
        #1;
        chk("clr_prio_busy", {63'd0, bus.busy}, 64'd0);

        //  op    sgn   a             b             hi            lo            dz
        run(1'b1, 1'b0, 32'd9,        32'd2,        32'h00000001, 32'h00000004, 1'b0, 0, 0);
        run(1'b1, 1'b1, 32'hFFFFFFF7, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFC, 1'b0, 0, 0);
        run(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0, 0);
        run(1'b0, 1'b1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 0, 0);
        run(1'b0, 1'b0, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 0, 0);
        run(1'b1, 1'b0, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 0, 0);
        run(1'b1, 1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 0, 0);
        run(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, 0);
        run(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 0, 0);
        run(1'b0, 1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0, 0);
        run(1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0, 0);
        run(1'b1, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 0, 0);
        run(1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 0, 0);
        run(1'b0, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 0, 0);
        // start pulsed mid-RUN is ignored
        run(1'b1, 1'b0, 32'd100,      32'd9,        32'h00000001, 32'h0000000B, 1'b0, 5, 0);
        // clear 10 cycles into RUN, then a normal request
        run(1'b0, 1'b0, 32'd6,        32'd7,        32'd0,        32'd0,        1'b0, 0, 10);
        run(1'b0, 1'b0, 32'd6,        32'd7,        32'h00000000, 32'h0000002A, 1'b0, 0, 0);

        // start held high: accepts every WIDTH+3 cycles
        t1 = 0;
        t2 = 0;
        bus.op    = 1'b0;
        bus.sgn   = 1'b0;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        bus.start = 1'b1;
        sb_q.push_back('{hi: 32'd0, lo: 32'd15, dz: 1'b0});
        sb_q.push_back('{hi: 32'd0, lo: 32'd15, dz: 1'b0});
        for (int k = 1; k <= 120 && t2 == 0; k++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                if (t1 == 0) t1 = k;
                else t2 = k;
            end
        end
        bus.start = 1'b0;
        chk("b2b_first", 64'(t1), 64'd34);
        chk("b2b_spacing", 64'(t2 - t1), 64'd35);

        repeat (4) @(posedge clock);
        #1;
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("hold_lo", {32'd0, bus.lo}, 64'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_muldiv.md
SEQ_MULDIV -- requirements
Module: seq_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving operand width in bits (legal range 4..64).
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  1  operation select: 0 = multiply, 1 = divide; sampled with start.
REQ-006 SHALL have port sgn  input  1  operand mode: 1 = two's-complement signed, 0 = unsigned; sampled with start.
REQ-007 SHALL have port a  input  WIDTH  multiplicand or dividend; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  multiplier or divisor; sampled with start.
REQ-009 SHALL have port busy  output  1  high in RUN and FIXUP.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse, high only in DONE.
REQ-011 SHALL have port hi  output  WIDTH  product upper half, or remainder (HI-register convention).
REQ-012 SHALL have port lo  output  WIDTH  product lower half, or quotient (LO-register convention).
REQ-013 SHALL have port div_zero  output  1  set when the completed divide had b == 0.

Function
REQ-014 SHALL implement states IDLE, RUN, FIXUP and DONE: IDLE->RUN on start; RUN->FIXUP after exactly WIDTH iterations; FIXUP->DONE; DONE->IDLE unconditionally.
REQ-015 SHALL capture op, sgn, a and b internally on the accepting edge; later input changes SHALL NOT affect the result.
REQ-016 SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step on operand magnitudes per RUN cycle.
REQ-017 SHALL, in FIXUP, apply sign correction when sgn = 1: product negated if the operand signs differ; quotient negated if the operand signs differ; remainder takes the sign of the dividend.
REQ-018 SHALL register hi, lo and div_zero on the FIXUP->DONE edge, so done rises WIDTH+1 edges after the accepting edge (33 for WIDTH = 32).
REQ-019 SHALL hold hi, lo and div_zero stable from DONE until the next result is registered.
REQ-020 SHALL produce for multiply the full 2*WIDTH-bit product, with hi:lo = a*b.
REQ-021 SHALL produce for divide a quotient truncated toward zero in lo and the remainder in hi, with a = lo*b + hi.
REQ-022 SHALL, when dividing with b == 0, still run the full latency and return lo = all ones, hi = a and div_zero = 1; div_zero SHALL be 0 for every other result.
REQ-023 SHALL return, for signed most-negative / -1, lo = most-negative value, hi = 0 and div_zero = 0.
REQ-024 SHALL ignore start outside IDLE: no restart, no queuing, no effect on the result in progress.
REQ-025 SHALL give done for exactly one cycle per accepted request; back-to-back requests are possible with start held high, yielding one accept every WIDTH+3 cycles.

Reset
REQ-026 SHALL, on clear = 1 at a rising edge, enter IDLE and drive busy = 0, done = 0, hi = 0, lo = 0 and div_zero = 0.
REQ-027 SHALL let clear abort a request in RUN, FIXUP or DONE with no done pulse and outputs zeroed.
REQ-028 SHALL give clear priority over start on the same edge; that start is not accepted.

Verification
REQ-029 SHALL cover: WIDTH = 32, op = 1, sgn = 0, a = 9, b = 2 -> done 33 edges after accept, lo = 0x00000004, hi = 0x00000001, div_zero = 0.
REQ-030 SHALL cover: op = 1, sgn = 1, a = 0xFFFFFFF7 (-9), b = 2 -> lo = 0xFFFFFFFC, hi = 0xFFFFFFFF; then a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-031 SHALL cover: op = 0, a = 0xFFFFFFFF, b = 2 -> sgn = 1 gives hi = 0xFFFFFFFF, lo = 0xFFFFFFFE; sgn = 0 gives hi = 0x00000001, lo = 0xFFFFFFFE.
REQ-032 SHALL cover: op = 1, a = 0x1234, b = 0 -> lo = 0xFFFFFFFF, hi = 0x00001234, div_zero = 1, latency unchanged.
REQ-033 SHALL cover: new start with different operands pulsed during RUN -> ignored, original result delivered, single done pulse.
REQ-034 SHALL cover: clear asserted 10 cycles into RUN -> next edge IDLE, busy = 0, hi = lo = 0, no done; a subsequent start then completes normally.
